// File: rtl/pad_poller.sv
// Serial NES/SNES pad poller: drives LATCH/PCLK, reads NUM_PADS pads in parallel and publishes whole frames.
// Define PAD_EDGE_EN to add registered per-frame pressed/released outputs.

module pad_poller #(
    parameter int NUM_PADS   = 2,
    parameter int BITS       = 8,
    parameter int DIV        = 6,
    parameter int ACTIVE_LOW = 1,
    parameter int AUTO       = 0
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic [NUM_PADS-1:0]      D,
    output logic                     LATCH,
    output logic                     PCLK,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic                     valid,
    output logic                     busy
`ifdef PAD_EDGE_EN
    ,
    output logic [NUM_PADS*BITS-1:0] pressed,
    output logic [NUM_PADS*BITS-1:0] released
`endif
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [PW-1:0]            phase_reg, phase_next;
    logic [BW-1:0]            bit_reg, bit_next;
    logic                     half_reg, half_next;
    logic                     capture;
    logic                     phase_last;

    logic                     latch_reg, pclk_reg, valid_reg, busy_reg;
    logic [NUM_PADS*BITS-1:0] buttons_reg;
    logic [NUM_PADS*BITS-1:0] shadow_all;

    assign phase_last = (phase_reg == PW'(DIV - 1));

    // Per-pad two-flop synchroniser and shadow frame; D is an asynchronous connector pin.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            logic            sync1_reg, sync2_reg;
            logic [BITS-1:0] shadow_reg;

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    shadow_reg <= '0;
                end else if (en) begin
                    sync1_reg <= D[gi];
                    sync2_reg <= sync1_reg;
                    if (capture)
                        shadow_reg[bit_reg] <= (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;
                end
            end

            assign shadow_all[gi*BITS +: BITS] = shadow_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        half_next  = half_reg;
        capture    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                phase_next = '0;
                bit_next   = '0;
                half_next  = 1'b0;
                if (start || (AUTO != 0))
                    state_next = S_LATCH;
            end
            S_LATCH: begin
                // The latch pulse is two phase-counter periods long; half_reg marks the second one.
                if (phase_last) begin
                    phase_next = '0;
                    if (half_reg) begin
                        half_next  = 1'b0;
                        bit_next   = '0;
                        state_next = S_LOW;
                    end else begin
                        half_next = 1'b1;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            S_LOW: begin
                if (phase_last) begin
                    phase_next = '0;
                    capture    = 1'b1;
                    state_next = S_HIGH;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            S_HIGH: begin
                if (phase_last) begin
                    phase_next = '0;
                    if (bit_reg == BW'(BITS - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        bit_next   = bit_reg + BW'(1);
                        state_next = S_LOW;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            phase_reg   <= '0;
            bit_reg     <= '0;
            half_reg    <= 1'b0;
            latch_reg   <= 1'b0;
            pclk_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            buttons_reg <= '0;
        end else if (en) begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            bit_reg   <= bit_next;
            half_reg  <= half_next;
            latch_reg <= (state_next == S_LATCH);
            pclk_reg  <= (state_next == S_HIGH);
            valid_reg <= (state_next == S_DONE);
            busy_reg  <= (state_next != S_IDLE);
            if (state_next == S_DONE)
                buttons_reg <= shadow_all;
        end
    end

`ifdef PAD_EDGE_EN
    logic [NUM_PADS*BITS-1:0] pressed_reg, released_reg;

    // buttons_reg still holds the previous frame when the new one is published.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pressed_reg  <= '0;
            released_reg <= '0;
        end else if (en && (state_next == S_DONE)) begin
            pressed_reg  <= shadow_all & ~buttons_reg;
            released_reg <= ~shadow_all & buttons_reg;
        end
    end

    assign pressed  = pressed_reg;
    assign released = released_reg;
`endif

    assign LATCH   = latch_reg;
    assign PCLK    = pclk_reg;
    assign valid   = valid_reg;
    assign busy    = busy_reg;
    assign buttons = buttons_reg;

endmodule

// File: tb/tb_pad_poller.sv
// Bench for pad_poller: an NES instance (2 pads, DIV=2) and an SNES instance (1 pad, BITS=16, DIV=3)
// driven by behavioural shift-register pads.

module tb_pad_poller;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        nes_start = 1'b0;
    logic        snes_start = 1'b0;

    logic [1:0]  nes_d;
    logic        nes_latch, nes_pclk, nes_valid, nes_busy;
    logic [15:0] nes_buttons;
    logic [0:0]  snes_d;
    logic        snes_latch, snes_pclk, snes_valid, snes_busy;
    logic [15:0] snes_buttons;
`ifdef PAD_EDGE_EN
    logic [15:0] nes_pressed, nes_released, snes_pressed, snes_released;
`endif

    int checks = 0;
    int errors = 0;

    pad_poller #(.NUM_PADS(2), .BITS(8), .DIV(2), .ACTIVE_LOW(1), .AUTO(0)) u_nes (
        .CLK(CLK), .reset(reset), .en(en), .start(nes_start), .D(nes_d),
        .LATCH(nes_latch), .PCLK(nes_pclk), .buttons(nes_buttons),
        .valid(nes_valid), .busy(nes_busy)
`ifdef PAD_EDGE_EN
        , .pressed(nes_pressed), .released(nes_released)
`endif
    );

    pad_poller #(.NUM_PADS(1), .BITS(16), .DIV(3), .ACTIVE_LOW(1), .AUTO(0)) u_snes (
        .CLK(CLK), .reset(reset), .en(en), .start(snes_start), .D(snes_d),
        .LATCH(snes_latch), .PCLK(snes_pclk), .buttons(snes_buttons),
        .valid(snes_valid), .busy(snes_busy)
`ifdef PAD_EDGE_EN
        , .pressed(snes_pressed), .released(snes_released)
`endif
    );

    // Behavioural pads: LATCH reloads, every PCLK rise moves to the next bit, 1 after the frame.
    logic [7:0]  nes_w [2];
    int          nes_idx = 0;
    logic [15:0] snes_w = 16'hFFFF;
    int          snes_idx = 0;

    always @(posedge nes_latch or posedge nes_pclk)
        if (nes_latch) nes_idx <= 0;
        else           nes_idx <= nes_idx + 1;

    always @(posedge snes_latch or posedge snes_pclk)
        if (snes_latch) snes_idx <= 0;
        else            snes_idx <= snes_idx + 1;

    always_comb begin
        for (int p = 0; p < 2; p++)
            nes_d[p] = (nes_idx < 8) ? nes_w[p][nes_idx[2:0]] : 1'b1;
        snes_d[0] = (snes_idx < 16) ? snes_w[snes_idx[3:0]] : 1'b1;
    end

    // Measurements of the last NES frame.
    int          m_valid_at, m_valid_edges, m_latch_cnt, m_pclk_pulses, m_pclk_high, m_valid_en_cnt;
    logic [15:0] m_buttons;
    logic        m_busy_end;
    bit          m_timeout;

    task automatic run_nes(input int stall_at, input int stall_len, input bit rnd_en);
        int n, edges, after;
        bit seen, prev;
        en = 1'b1;
        nes_start = 1'b1;
        @(posedge CLK); #1;
        nes_start = 1'b0;
        n = 1; edges = 0; after = 0; seen = 0; prev = 0;
        m_valid_at = 0; m_valid_edges = 0; m_latch_cnt = 0; m_pclk_pulses = 0;
        m_pclk_high = 0; m_valid_en_cnt = 0; m_buttons = '0; m_timeout = 0;
        while (after < 3) begin
            if (nes_latch) m_latch_cnt++;
            if (nes_pclk) m_pclk_high++;
            if (nes_pclk && !prev) m_pclk_pulses++;
            prev = nes_pclk;
            if (n >= stall_at && n < stall_at + stall_len) en = 1'b0;
            else if (rnd_en) en = ($urandom_range(0, 3) != 0);
            else en = 1'b1;
            if (nes_valid) begin
                if (!seen) begin
                    seen = 1;
                    m_valid_at = n;
                    m_valid_edges = edges;
                    m_buttons = nes_buttons;
                end
                if (en) m_valid_en_cnt++;
            end
            if (seen && en) after++;
            if (en) edges++;
            if (n > 600) begin
                m_timeout = 1;
                break;
            end
            @(posedge CLK); #1;
            n++;
        end
        en = 1'b1;
        m_busy_end = nes_busy;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({nes_latch, nes_pclk, nes_valid, nes_busy, nes_buttons} !== 20'h0) begin
            errors++;
            $display("FAIL reset_nes: latch/pclk/valid/busy/buttons=%b/%b/%b/%b/%h required all 0",
                     nes_latch, nes_pclk, nes_valid, nes_busy, nes_buttons);
        end
        checks++;
        if ({snes_latch, snes_pclk, snes_valid, snes_busy, snes_buttons} !== 20'h0) begin
            errors++;
            $display("FAIL reset_snes: latch/pclk/valid/busy/buttons=%b/%b/%b/%b/%h required all 0",
                     snes_latch, snes_pclk, snes_valid, snes_busy, snes_buttons);
        end
        #20 reset = 1'b0;
        @(posedge CLK); #1;
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_basic;
        nes_w[0] = 8'b1111_1110;
        nes_w[1] = 8'b0111_1111;
        run_nes(0, 0, 0);
        checks++;
        if (m_timeout) begin errors++; $display("FAIL basic_timeout: no valid within 600 cycles, required valid"); end
        checks++;
        if (m_valid_at != 37) begin errors++; $display("FAIL basic_valid_at: got %0d required 37", m_valid_at); end
        checks++;
        if (m_buttons !== 16'h8001) begin errors++; $display("FAIL basic_buttons: got %h required 8001", m_buttons); end
        checks++;
        if (m_latch_cnt != 4) begin errors++; $display("FAIL basic_latch_len: got %0d required 4", m_latch_cnt); end
        checks++;
        if (m_pclk_pulses != 8 || m_pclk_high != 16) begin
            errors++;
            $display("FAIL basic_pclk: pulses %0d high %0d required 8 and 16", m_pclk_pulses, m_pclk_high);
        end
        checks++;
        if (m_valid_en_cnt != 1 || m_busy_end !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_once: valid cycles %0d busy %b required 1 and 0", m_valid_en_cnt, m_busy_end);
        end
        checks++;
        if (nes_buttons !== 16'h8001) begin errors++; $display("FAIL basic_hold: got %h required 8001", nes_buttons); end
        $display("basic: buttons=%h valid_at=%0d latch=%0d pulses=%0d", m_buttons, m_valid_at, m_latch_cnt, m_pclk_pulses);
    endtask

    task automatic test_snes;
        int n, valid_at, pulses;
        bit prev, seen;
        logic [15:0] got;
        for (int f = 0; f < 2; f++) begin
            snes_w = (f == 0) ? 16'h0000 : 16'($urandom);
            snes_start = 1'b1;
            @(posedge CLK); #1;
            snes_start = 1'b0;
            n = 1; valid_at = 0; pulses = 0; prev = 0; seen = 0; got = '0;
            while (n < 300 && !seen) begin
                if (snes_pclk && !prev) pulses++;
                prev = snes_pclk;
                if (snes_valid) begin
                    seen = 1;
                    valid_at = n;
                    got = snes_buttons;
                end
                @(posedge CLK); #1;
                n++;
            end
            @(posedge CLK); #1;
            checks++;
            if (valid_at != 103) begin errors++; $display("FAIL snes_valid_at: got %0d required 103", valid_at); end
            checks++;
            if (got !== ~snes_w) begin errors++; $display("FAIL snes_buttons: got %h required %h", got, ~snes_w); end
            checks++;
            if (pulses != 16) begin errors++; $display("FAIL snes_pulses: got %0d required 16", pulses); end
            $display("snes: frame %0d data=%h buttons=%h valid_at=%0d pulses=%0d", f, snes_w, got, valid_at, pulses);
        end
    endtask

    task automatic test_random;
        logic [15:0] exp;
        for (int f = 0; f < 8; f++) begin
            nes_w[0] = 8'($urandom);
            nes_w[1] = 8'($urandom);
            exp = {~nes_w[1], ~nes_w[0]};
            run_nes(0, 0, 1);
            checks++;
            if (m_timeout || m_buttons !== exp) begin
                errors++;
                $display("FAIL random_buttons: got %h required %h (timeout %0d)", m_buttons, exp, m_timeout);
            end
            checks++;
            if (m_valid_edges != 36 || m_valid_en_cnt != 1) begin
                errors++;
                $display("FAIL random_timing: enabled edges %0d valid cycles %0d required 36 and 1",
                         m_valid_edges, m_valid_en_cnt);
            end
            $display("random: frame %0d buttons=%h expected=%h valid_at=%0d", f, m_buttons, exp, m_valid_at);
        end
    endtask

    task automatic test_en_stall;
        logic [15:0] exp;
        nes_w[0] = 8'($urandom);
        nes_w[1] = 8'($urandom);
        exp = {~nes_w[1], ~nes_w[0]};
        run_nes(2, 10, 0);
        checks++;
        if (m_latch_cnt != 14) begin errors++; $display("FAIL en_latch_len: got %0d required 14", m_latch_cnt); end
        checks++;
        if (m_valid_at != 47) begin errors++; $display("FAIL en_valid_at: got %0d required 47", m_valid_at); end
        checks++;
        if (m_buttons !== exp) begin errors++; $display("FAIL en_buttons: got %h required %h", m_buttons, exp); end
        $display("en_stall: latch=%0d valid_at=%0d buttons=%h", m_latch_cnt, m_valid_at, m_buttons);
    endtask

    task automatic test_start_ignored;
        int vcnt, cnt;
        logic [15:0] exp;
        nes_w[0] = 8'($urandom);
        nes_w[1] = 8'($urandom);
        exp = {~nes_w[1], ~nes_w[0]};
        en = 1'b1;
        nes_start = 1'b1;
        @(posedge CLK); #1;
        nes_start = 1'b0;
        vcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (nes_valid) vcnt++;
            if (n == 37) begin
                checks++;
                if (nes_valid !== 1'b1 || nes_busy !== 1'b1 || nes_buttons !== exp) begin
                    errors++;
                    $display("FAIL start_done: valid %b busy %b buttons %h required 1 1 %h",
                             nes_valid, nes_busy, nes_buttons, exp);
                end
            end
            if (n == 38) begin
                checks++;
                if (nes_busy !== 1'b0 || nes_valid !== 1'b0 || vcnt != 1) begin
                    errors++;
                    $display("FAIL start_idle_gap: busy %b valid %b valid count %0d required 0 0 1",
                             nes_busy, nes_valid, vcnt);
                end
            end
            if (n == 39) begin
                checks++;
                if (nes_busy !== 1'b1 || nes_latch !== 1'b1) begin
                    errors++;
                    $display("FAIL start_restart: busy %b latch %b required 1 1", nes_busy, nes_latch);
                end
            end
            nes_start = (n == 17) || (n >= 30 && n <= 38);
            @(posedge CLK); #1;
        end
        nes_start = 1'b0;
        cnt = 0;
        while (nes_busy && cnt < 200) begin
            @(posedge CLK); #1;
            cnt++;
        end
        checks++;
        if (cnt >= 200) begin errors++; $display("FAIL start_drain: busy still %b after 200 cycles, required 0", nes_busy); end
        $display("start_ignored: valid pulses in first frame=%0d", vcnt);
    endtask

    task automatic test_reset_midframe;
        int vcnt;
        logic [15:0] exp;
        nes_w[0] = 8'h00;
        nes_w[1] = 8'hFF;
        run_nes(0, 0, 0);
        checks++;
        if (nes_buttons !== 16'h00FF) begin errors++; $display("FAIL rst_pre: got %h required 00FF", nes_buttons); end
        nes_w[0] = 8'($urandom);
        nes_w[1] = 8'($urandom);
        nes_start = 1'b1;
        @(posedge CLK); #1;
        nes_start = 1'b0;
        repeat (26) begin @(posedge CLK); #1; end
        checks++;
        if (nes_pclk !== 1'b1) begin errors++; $display("FAIL rst_in_high: pclk %b required 1 at bit 5 high", nes_pclk); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({nes_buttons, nes_latch, nes_pclk, nes_busy, nes_valid} !== 20'h0) begin
            errors++;
            $display("FAIL rst_immediate: buttons %h latch %b pclk %b busy %b valid %b required all 0",
                     nes_buttons, nes_latch, nes_pclk, nes_busy, nes_valid);
        end
        @(posedge CLK); #1;
        reset = 1'b0;
        vcnt = 0;
        repeat (40) begin
            if (nes_valid) vcnt++;
            @(posedge CLK); #1;
        end
        checks++;
        if (vcnt != 0 || nes_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_valid: valid count %0d busy %b required 0 0", vcnt, nes_busy);
        end
        exp = {~nes_w[1], ~nes_w[0]};
        run_nes(0, 0, 0);
        checks++;
        if (m_buttons !== exp || m_valid_at != 37) begin
            errors++;
            $display("FAIL rst_next_frame: buttons %h valid_at %0d required %h 37", m_buttons, m_valid_at, exp);
        end
        $display("reset_midframe: next frame buttons=%h valid_at=%0d", m_buttons, m_valid_at);
    endtask

`ifdef PAD_EDGE_EN
    task automatic test_edges;
        logic [7:0]  seq [3];
        logic [15:0] exp_p [3];
        logic [15:0] exp_r [3];
        seq[0] = 8'hFE; seq[1] = 8'hFC; seq[2] = 8'hFD;
        exp_p[0] = 16'h0001; exp_p[1] = 16'h0002; exp_p[2] = 16'h0000;
        exp_r[0] = 16'h0000; exp_r[1] = 16'h0000; exp_r[2] = 16'h0001;
        #2 reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        for (int f = 0; f < 3; f++) begin
            nes_w[0] = seq[f];
            nes_w[1] = 8'hFF;
            run_nes(0, 0, 0);
            checks++;
            if (nes_pressed !== exp_p[f] || nes_released !== exp_r[f]) begin
                errors++;
                $display("FAIL edge_frame%0d: pressed %h released %h required %h %h",
                         f, nes_pressed, nes_released, exp_p[f], exp_r[f]);
            end
            $display("edges: frame %0d pressed=%h released=%h", f, nes_pressed, nes_released);
        end
    endtask
`endif

    initial begin
        nes_w[0] = 8'hFF;
        nes_w[1] = 8'hFF;
        test_reset();
        test_basic();
        test_snes();
        test_random();
        test_en_stall();
        test_start_ignored();
        test_reset_midframe();
`ifdef PAD_EDGE_EN
        test_edges();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_poller.md
# pad_poller

Parametrised serial game-pad poller, the successor to the single-port 8-bit NES driver. It generates the latch pulse and pad clock itself, at a rate derived from the system clock. It reads up to four pads in parallel, in either NES (8-bit) or SNES (16-bit) frame length, and presents a debounced-by-frame parallel button word. It sits between the pad connector pins and game logic, with one `valid` pulse per completed frame.

## Interface
Parameters:
- `NUM_PADS`, 2: number of pads polled in parallel, 1..4.
- `BITS`, 8: bits per frame; 8 = NES, 16 = SNES.
- `DIV`, 6: `CLK` cycles per half-period of `PCLK` and per half of the latch pulse; must be ≥1.
- `ACTIVE_LOW`, 1: 1 means pad data is low when a button is pressed and is inverted on capture; 0 means no inversion.
- `AUTO`, 0: 1 means a new poll starts on every return to IDLE without `start`.

Ports:
- `CLK` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: clock enable; low freezes all state and holds all outputs.
- `start` in 1: poll request; sampled only in IDLE.
- `D` in NUM_PADS: serial data, one bit per pad; `D[p]` belongs to pad p.
- `LATCH` out 1: parallel-load strobe to all pads.
- `PCLK` out 1: shift clock to all pads; idles low.
- `buttons` out NUM_PADS*BITS: `buttons[p*BITS+i]` is pad p, bit i; 1 = pressed.
- `valid` out 1: one-cycle pulse when `buttons` has just been updated.
- `busy` out 1: high in any state except IDLE.
- `pressed`, `released` out NUM_PADS*BITS: present only with `PAD_EDGE_EN`.

## Operation
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
- Counters:
  - phase counter, $clog2(DIV) bits, counts 0..DIV-1;
  - bit counter, $clog2(BITS) bits, counts 0..BITS-1.
- IDLE:
  - `LATCH`=0, `PCLK`=0.
  - Goes to LATCH if `start`, or if `AUTO`=1.
- LATCH:
  - `LATCH`=1 for 2*DIV cycles, then goes to LOW with bit counter = 0.
- LOW:
  - `PCLK`=0 for DIV cycles.
  - On the last LOW cycle, every pad's `D[p]` is captured into shadow bit [p*BITS+bit], inverted if `ACTIVE_LOW`.
  - Then goes to HIGH.
- HIGH:
  - `PCLK`=1 for DIV cycles; pads shift on the rising edge.
  - If bit counter = BITS-1, goes to DONE; otherwise increments the bit counter and goes to LOW.
- DONE, one cycle:
  - `buttons` is loaded from the shadow register all at once, so a partial frame is never visible.
  - `valid`=1; goes to IDLE.
- `start` in any state other than IDLE is ignored and not queued.
- Bit 0 is the first bit out after the latch (NES order: A, B, Select, Start, Up, Down, Left, Right).
- `en`=0:
  - FSM, counters, shadow register and outputs hold.
  - A `valid` pulse pending in DONE is held until `en` returns, so it is seen for exactly one enabled cycle.
- Reset, asynchronous, in any state including mid-frame:
  - FSM goes to IDLE.
  - Counters = 0.
  - `LATCH`=0, `PCLK`=0, `valid`=0, `busy`=0.
  - `buttons`=0, shadow register = 0, edge outputs = 0.
  - The partial frame is discarded.

## Timing
- `start` is accepted at rising edge k.
- `LATCH` is high in cycles k+1 .. k+2*DIV.
- Bit i:
  - LOW spans k+2*DIV*(i+1)+1 .. k+2*DIV*(i+1)+DIV;
  - HIGH spans the next DIV cycles.
- `valid` is high in cycle k+2*DIV*(BITS+1)+1.
- `busy` is high from k+1 through the DONE cycle.
- Earliest next `start` acceptance is the edge ending the first IDLE cycle after DONE.
- Worst-case frame period is 2*DIV*(BITS+1)+2 cycles, with `AUTO`=1 or with `start` held.
- `LATCH` and `PCLK` are registered outputs and glitch-free.
- `D` is an asynchronous pin; a two-flop synchroniser per pad precedes the capture point. It adds 2 cycles of input delay, which is covered because DIV ≥ 2 is required when `D` is driven from the connector.

## Configuration
- `PAD_EDGE_EN` defined:
  - `pressed` and `released` ports exist; both are registered and updated in DONE together with `buttons`, and held between frames.
  - `pressed` = new & ~old.
  - `released` = ~new & old.
  - "old" is the previous `buttons` value; it is 0 after reset, so the first frame reports every held button as pressed.
- `PAD_EDGE_EN` undefined:
  - The ports and the previous-frame register are absent; all other behaviour is identical.

## Test plan
- Basic read. Config: NUM_PADS=2, BITS=8, DIV=2, ACTIVE_LOW=1.
  - Stimulus: pad0 serves 8'b1111_1110 (A pressed), pad1 serves 8'b0111_1111 (Right pressed), LSB first.
  - Required: `buttons`=16'h8001 and `valid` pulses at cycle 37 after start.
  - Required: `LATCH` is high for exactly 4 cycles, with 8 `PCLK` pulses of 2 high cycles each.
- SNES frame. Config: BITS=16, DIV=3, pad0 returns all-zero data.
  - Required: `buttons[15:0]`=16'hFFFF, `valid` at cycle 2*3*17+1=103, and 16 `PCLK` pulses.
- `start` pulsed during LOW of bit 3.
  - Required: no restart; exactly one `valid`; `busy` low for one cycle after DONE before any new frame.
- `reset` asserted during HIGH of bit 5, after a previous frame left `buttons`=16'h00FF.
  - Required: `buttons`=0, `LATCH`/`PCLK`/`busy`=0 immediately; no `valid`.
  - Required: the next `start` yields a full, correct frame.
- `en` held low for 10 cycles mid-LATCH.
  - Required: the `LATCH` pulse stretches by exactly 10 cycles and the frame data is unchanged.
- With `PAD_EDGE_EN`, frames A then A+B then B.
  - Required: `pressed`=0x01, then 0x02, then 0x00.
  - Required: `released`=0x00, then 0x00, then 0x01.
